// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Reads a scanned, active-low 7-segment display (segment bus + anode selects).
// Each digit's pattern must stay stable before it is decoded back to hex.
// Optional feature macro: SEG7_SCAN_DP_EN (adds dp_in / dp_out decimal-point tracking).
module seg7_scan_decoder #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
`ifdef SEG7_SCAN_DP_EN
    input  logic                  dp_in,
    output logic [DIGITS-1:0]     dp_out,
`endif
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   value_out,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  upd_pulse,
    output logic [2:0]            upd_digit,
    output logic                  err_sticky
);

`ifdef SEG7_SCAN_DP_EN
    localparam int SW = 8;
`else
    localparam int SW = 7;
`endif
    localparam logic [3:0]        CNT_MAX = 4'(STABLE_CNT);
    localparam logic [DIGITS-1:0] AN_ONE  = DIGITS'(1);

    // Decode g..a to {legal, blank, code}
    function automatic logic [5:0] seg7_decode(input logic [6:0] p);
        logic [5:0] d;
        case (p)
            7'b1000000: d = {2'b10, 4'h0};
            7'b1111001: d = {2'b10, 4'h1};
            7'b0100100: d = {2'b10, 4'h2};
            7'b0110000: d = {2'b10, 4'h3};
            7'b0011001: d = {2'b10, 4'h4};
            7'b0010010: d = {2'b10, 4'h5};
            7'b0000010: d = {2'b10, 4'h6};
            7'b1111000: d = {2'b10, 4'h7};
            7'b0000000: d = {2'b10, 4'h8};
            7'b0010000: d = {2'b10, 4'h9};
            7'b0001000: d = {2'b10, 4'hA};
            7'b0000011: d = {2'b10, 4'hB};
            7'b1000110: d = {2'b10, 4'hC};
            7'b0100001: d = {2'b10, 4'hD};
            7'b0000110: d = {2'b10, 4'hE};
            7'b0001110: d = {2'b10, 4'hF};
            7'b1111111: d = {2'b01, 4'h0};
            default:    d = {2'b00, 4'h0};
        endcase
        return d;
    endfunction

    logic [SW-1:0]       w_raw;
    logic [SW-1:0]       r_smp_s1, r_smp_s2, r_prev_smp;
    logic [DIGITS-1:0]   r_an_s1, r_an_s2, r_prev_an;
    logic [1:0]          r_fill;
    logic [3:0]          r_cnt, w_cnt_nxt;
    logic [DIGITS-1:0]   w_low;
    logic                w_primed, w_idle, w_multi, w_sel, w_same, w_commit;
    logic [2:0]          w_idx;
    logic [5:0]          w_dec;
    logic [4*DIGITS-1:0] w_val_nxt;
    logic [DIGITS-1:0]   w_vld_nxt;
    logic                w_err_nxt;

`ifdef SEG7_SCAN_DP_EN
    logic [DIGITS-1:0]   w_dp_nxt;
    assign w_raw = {dp_in, seg_in};
`else
    assign w_raw = seg_in;
`endif

    // The synchronizer resets to zero, which would read as "all anodes on";
    // samples are ignored until real input has reached the second stage.
    assign w_primed = (r_fill == 2'd2);
    assign w_low    = ~r_an_s2;
    assign w_idle   = !w_primed || (w_low == {DIGITS{1'b0}});
    assign w_multi  = w_primed && ((w_low & (w_low - AN_ONE)) != {DIGITS{1'b0}});
    assign w_sel    = !w_idle && !w_multi;
    assign w_same   = (r_an_s2 == r_prev_an) && (r_smp_s2 == r_prev_smp);
    assign w_dec    = seg7_decode(r_smp_s2[6:0]);

    // One-hot anode vector to digit index
    always_comb begin
        w_idx = 3'd0;
        for (int k = 0; k < DIGITS; k++) begin
            w_idx = w_low[k] ? 3'(k) : w_idx;
        end
    end

    // Stability counter next value and commit detection (once per stable run)
    always_comb begin
        w_cnt_nxt = 4'd0;
        w_commit  = 1'b0;
        if (w_sel) begin
            if (w_same) begin
                w_cnt_nxt = (r_cnt >= CNT_MAX) ? CNT_MAX : (r_cnt + 4'd1);
            end else begin
                w_cnt_nxt = 4'd1;
            end
            w_commit = (w_cnt_nxt == CNT_MAX) && !(w_same && (r_cnt == CNT_MAX));
        end else begin
            w_cnt_nxt = 4'd0;
        end
    end

    // Next state of the digit registers; clr takes priority over a commit
    always_comb begin
        w_val_nxt = value_out;
        w_vld_nxt = digit_valid;
        w_err_nxt = err_sticky;
`ifdef SEG7_SCAN_DP_EN
        w_dp_nxt  = dp_out;
`endif
        if (clr) begin
            w_val_nxt = {(4*DIGITS){1'b0}};
            w_vld_nxt = {DIGITS{1'b0}};
            w_err_nxt = 1'b0;
`ifdef SEG7_SCAN_DP_EN
            w_dp_nxt  = {DIGITS{1'b0}};
`endif
        end else begin
            if (w_multi) begin
                w_err_nxt = 1'b1;
            end else begin
                w_err_nxt = err_sticky;
            end
            for (int k = 0; k < DIGITS; k++) begin
                if (w_commit && (w_idx == 3'(k))) begin
`ifdef SEG7_SCAN_DP_EN
                    w_dp_nxt[k] = ~r_smp_s2[7];
`endif
                    if (w_dec[5]) begin
                        w_val_nxt[4*k +: 4] = w_dec[3:0];
                        w_vld_nxt[k]        = 1'b1;
                    end else begin
                        w_vld_nxt[k] = 1'b0;
                        if (!w_dec[4]) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_err_nxt = w_err_nxt;
                        end
                    end
                end else begin
                    w_vld_nxt[k] = w_vld_nxt[k];
                end
            end
        end
    end

    // Input synchronizers, previous-sample history and stability counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_smp_s1   <= {SW{1'b0}};
            r_smp_s2   <= {SW{1'b0}};
            r_an_s1    <= {DIGITS{1'b0}};
            r_an_s2    <= {DIGITS{1'b0}};
            r_prev_smp <= {SW{1'b1}};
            r_prev_an  <= {DIGITS{1'b1}};
            r_fill     <= 2'd0;
            r_cnt      <= 4'd0;
        end else begin
            r_smp_s1   <= w_raw;
            r_smp_s2   <= r_smp_s1;
            r_an_s1    <= an_in;
            r_an_s2    <= r_an_s1;
            r_prev_smp <= r_smp_s2;
            r_prev_an  <= r_an_s2;
            if (r_fill != 2'd2) begin
                r_fill <= r_fill + 2'd1;
            end
            r_cnt      <= w_cnt_nxt;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_out   <= {(4*DIGITS){1'b0}};
            digit_valid <= {DIGITS{1'b0}};
            upd_pulse   <= 1'b0;
            upd_digit   <= 3'd0;
            err_sticky  <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
            dp_out      <= {DIGITS{1'b0}};
`endif
        end else begin
            value_out   <= w_val_nxt;
            digit_valid <= w_vld_nxt;
            upd_pulse   <= w_commit;
            err_sticky  <= w_err_nxt;
            if (w_commit) begin
                upd_digit <= w_idx;
            end
`ifdef SEG7_SCAN_DP_EN
            dp_out      <= w_dp_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed, table-driven bench for seg7_scan_decoder (DIGITS=4, STABLE_CNT=3).
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic        clr;
    logic [15:0] value_out;
    logic [3:0]  digit_valid;
    logic        upd_pulse;
    logic [2:0]  upd_digit;
    logic        err_sticky;
`ifdef SEG7_SCAN_DP_EN
    logic        dp_in = 1'b1;
    logic [3:0]  dp_out;
`endif

    int n_checks = 0;
    int n_errors = 0;

    seg7_scan_decoder #(.DIGITS(4), .STABLE_CNT(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
`ifdef SEG7_SCAN_DP_EN
        .dp_in       (dp_in),
        .dp_out      (dp_out),
`endif
        .clr         (clr),
        .value_out   (value_out),
        .digit_valid (digit_valid),
        .upd_pulse   (upd_pulse),
        .upd_digit   (upd_digit),
        .err_sticky  (err_sticky)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] P1 = 7'b1111001, P2 = 7'b0100100, P7 = 7'b1111000;
    localparam logic [6:0] P8 = 7'b0000000, P9 = 7'b0010000, PA = 7'b0001000;
    localparam logic [6:0] PB = 7'b0000011, PD = 7'b0100001, PF = 7'b0001110;
    localparam logic [6:0] PBLK = 7'b1111111, PBAD = 7'b1010101;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          cycles;
        int          pulses;
        logic [15:0] value;
        logic [3:0]  valid;
        logic        err;
        logic [2:0]  digit;
    } vec_t;

    vec_t tbl [0:15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_row(input int i);
        int np;
        np = 0;
        an_in  = tbl[i].an;
        seg_in = tbl[i].seg;
        for (int c = 0; c < tbl[i].cycles; c++) begin
            step();
            if (upd_pulse) np++;
        end
        chk($sformatf("row%0d_pulses", i), np, tbl[i].pulses);
        chk($sformatf("row%0d_value", i), value_out, tbl[i].value);
        chk($sformatf("row%0d_valid", i), digit_valid, tbl[i].valid);
        chk($sformatf("row%0d_err", i), err_sticky, tbl[i].err);
        chk($sformatf("row%0d_digit", i), upd_digit, tbl[i].digit);
    endtask

    initial begin
        int np;
        int first_edge;

        tbl[0]  = '{4'b1110, P1,   8, 1, 16'h0001, 4'b0001, 1'b0, 3'd0};
        tbl[1]  = '{4'b1101, PA,   8, 1, 16'h00A1, 4'b0011, 1'b0, 3'd1};
        tbl[2]  = '{4'b1011, PD,   8, 1, 16'h0DA1, 4'b0111, 1'b0, 3'd2};
        tbl[3]  = '{4'b0111, PF,   8, 1, 16'hFDA1, 4'b1111, 1'b0, 3'd3};
        tbl[4]  = '{4'b1101, P7,   2, 0, 16'hFDA1, 4'b1111, 1'b0, 3'd3};
        tbl[5]  = '{4'b1101, P1,   2, 0, 16'hFDA1, 4'b1111, 1'b0, 3'd3};
        tbl[6]  = '{4'b1101, P7,   2, 0, 16'hFDA1, 4'b1111, 1'b0, 3'd3};
        tbl[7]  = '{4'b1101, P1,   2, 0, 16'hFDA1, 4'b1111, 1'b0, 3'd3};
        tbl[8]  = '{4'b1101, P7,   2, 0, 16'hFDA1, 4'b1111, 1'b0, 3'd3};
        tbl[9]  = '{4'b1101, P1,   2, 0, 16'hFDA1, 4'b1111, 1'b0, 3'd3};
        tbl[10] = '{4'b1101, P7,   8, 1, 16'hFD71, 4'b1111, 1'b0, 3'd1};
        tbl[11] = '{4'b1011, P8,   8, 1, 16'h0800, 4'b0100, 1'b0, 3'd2};
        tbl[12] = '{4'b1011, PBAD, 8, 1, 16'h0800, 4'b0000, 1'b1, 3'd2};
        tbl[13] = '{4'b1011, PBLK, 8, 1, 16'h0800, 4'b0000, 1'b1, 3'd2};
        tbl[14] = '{4'b1110, P9,   8, 1, 16'h0809, 4'b0001, 1'b1, 3'd0};
        tbl[15] = '{4'b1110, PBLK, 8, 1, 16'h0809, 4'b0000, 1'b1, 3'd0};

        // Reset state
        rst_n  = 1'b0;
        clr    = 1'b0;
        an_in  = 4'b1111;
        seg_in = PBLK;
        step();
        step();
        chk("rst_value", value_out, 16'h0000);
        chk("rst_valid", digit_valid, 4'b0000);
        chk("rst_pulse", upd_pulse, 1'b0);
        chk("rst_digit", upd_digit, 3'd0);
        chk("rst_err", err_sticky, 1'b0);

        // First commit latency: change before edge 1, pulse after edge 5
        rst_n  = 1'b1;
        an_in  = 4'b1110;
        seg_in = P2;
        np = 0;
        first_edge = 0;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (upd_pulse) begin
                np++;
                if (first_edge == 0) first_edge = e;
            end
        end
        chk("lat_edge", first_edge, 5);
        chk("lat_count", np, 1);
        chk("lat_digit", upd_digit, 3'd0);
        chk("lat_value", value_out[3:0], 4'h2);
        chk("lat_valid", digit_valid, 4'b0001);

        // Scan of four digits, toggling rejection, then stable hold
        for (int i = 0; i <= 10; i++) run_row(i);

        // Two anodes active for one cycle
        an_in = 4'b1100;
        seg_in = P7;
        step();
        an_in = 4'b1111;
        np = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (upd_pulse) np++;
        end
        chk("multi_pulses", np, 0);
        chk("multi_err", err_sticky, 1'b1);

        // clr
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_err", err_sticky, 1'b0);
        chk("clr_value", value_out, 16'h0000);
        chk("clr_valid", digit_valid, 4'b0000);

        // Legal, illegal and blank patterns
        for (int i = 11; i <= 15; i++) run_row(i);

        // clr in the same cycle as a commit
        an_in  = 4'b1101;
        seg_in = PB;
        np = 0;
        for (int e = 1; e <= 4; e++) begin
            step();
            if (upd_pulse) np++;
        end
        chk("clrc_early", np, 0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clrc_pulse", upd_pulse, 1'b1);
        chk("clrc_digit", upd_digit, 3'd1);
        chk("clrc_value", value_out, 16'h0000);
        chk("clrc_valid", digit_valid, 4'b0000);
        chk("clrc_err", err_sticky, 1'b0);
        step();
        chk("clrc_width", upd_pulse, 1'b0);
        chk("clrc_hold", value_out, 16'h0000);

        // Asynchronous reset mid-run
        an_in  = 4'b1110;
        seg_in = P2;
        for (int e = 1; e <= 7; e++) step();
        chk("pre_rst_value", value_out, 16'h0002);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_value", value_out, 16'h0000);
        chk("arst_valid", digit_valid, 4'b0000);
        chk("arst_digit", upd_digit, 3'd0);
        #2;
        rst_n = 1'b1;
        np = 0;
        first_edge = 0;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (upd_pulse) begin
                np++;
                if (first_edge == 0) first_edge = e;
            end
        end
        chk("arst_lat_edge", first_edge, 5);
        chk("arst_lat_count", np, 1);
        chk("arst_re_value", value_out, 16'h0002);
        chk("arst_re_valid", digit_valid, 4'b0001);
        chk("arst_re_err", err_sticky, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Decoder for multiplexed, active-low 7-segment display lines: the inverse of the hex-to-segment encoder used on the board displays.
- Samples the segment bus and the anode-select bus of a scanned display, qualifies each digit's pattern for stability, and decodes it back to a 4-bit hex value per digit.
- Used by the on-chip display self-check and to read an external scanned display into the processor's register space.

Parameters:
- DIGITS, 4, number of scanned digits (anode lines), 1..8
- STABLE_CNT, 3, consecutive identical samples required before commit, 1..15

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- seg_in  input  7  segment lines, active-low; bit0=a … bit6=g
- an_in  input  DIGITS  anode selects, active-low, one-hot when valid
- clr  input  1  synchronous clear of values, valid flags, error flag
- value_out  output  4*DIGITS  decoded hex per digit; digit i at [4i+3:4i]
- digit_valid  output  DIGITS  digit i holds a committed valid value
- upd_pulse  output  1  one-cycle strobe on every commit
- upd_digit  output  3  index of the digit committed with upd_pulse
- err_sticky  output  1  set on illegal pattern or multi-anode; cleared by clr/reset

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, synchronizers 0, stability counter 0, previous-sample registers all-ones.
- Input capture:
  - seg_in and an_in each pass through a 2-flop synchronizer.
  - All logic below operates on the second stage.
- Sample classification, each cycle:
  - IDLE: an_in all ones.
  - SEL(i): exactly one bit low, at index i.
  - MULTI: more than one bit low.
- Stability counter (saturating at STABLE_CNT):
  - IDLE: counter := 0; no commit.
  - MULTI: counter := 0; err_sticky := 1.
  - SEL(i) with (i, seg) equal to previous sample: counter := min(counter+1, STABLE_CNT).
  - SEL(i) otherwise: counter := 1.
  - Previous-sample registers update every cycle.
- Commit:
  - Occurs on the edge where the counter transitions to STABLE_CNT, once per stable run.
  - No re-commit while the run holds.
  - With STABLE_CNT=1, every change of (i, seg) commits.
- Decode at commit, on the 7-bit pattern g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Commit outcome:
  - Legal pattern: value_out[i] := code; digit_valid[i] := 1; upd_pulse := 1; upd_digit := i.
  - Blank 1111111: digit_valid[i] := 0; value_out[i] unchanged; upd_pulse := 1; no error.
  - Any other pattern: digit_valid[i] := 0; err_sticky := 1; upd_pulse := 1.
- Latency: a change presented before clock edge #1 and held produces upd_pulse high after edge #(STABLE_CNT+2). For the default, that is edge #5.
- upd_pulse is exactly one cycle wide; upd_digit holds its last value between pulses.
- clr:
  - Same cycle as a commit: clr wins for value_out, digit_valid and err_sticky; upd_pulse still fires.
  - clr does not reset the stability counter.
- Reset mid-run: the counter restarts. After release, a held stable input commits again after the full latency.
- Digit index i >= DIGITS cannot occur. Unused upd_digit MSBs are 0.

Optional Feature:
- Macro: SEG7_SCAN_DP_EN.
- Defined:
  - Adds input dp_in (1, active-low decimal point, synchronized like seg_in) and output dp_out (DIGITS).
  - dp_in is part of the stability comparison.
  - Each commit writes dp_out[i] := ~dp_in; reset and clr clear it.
- Undefined: ports absent; behaviour identical to the above.

Test Plan:
- Reset, then an_in=1110 with seg_in=0100100 held 10 cycles → one upd_pulse at edge 5; upd_digit=0; value_out[3:0]=2; digit_valid=0001.
- Scan digits 0..3 with patterns for 1, A, d, F, 8 cycles each → value_out=16'hFDA1, digit_valid=1111, four upd_pulses, err_sticky=0.
- seg_in toggles every 2 cycles between patterns 7 and 1 on digit 1 (STABLE_CNT=3) → no commit; then hold 7 → commit; value_out[7:4]=7.
- an_in=1100 for 1 cycle → err_sticky=1, no upd_pulse; then clr → err_sticky=0, value_out=0, digit_valid=0.
- Digit 2 holds illegal pattern 1010101 → upd_pulse, upd_digit=2, digit_valid[2]=0, err_sticky=1. Then blank 1111111 → upd_pulse, no further effect.
- rst_n pulled low asynchronously mid-run between clock edges → outputs 0 immediately; after release, held input commits again at edge 5.
